// File: rtl/data_bus_pkg.sv
// data_bus_pkg: shared state encoding and width helper for the arbitrated data bus
package data_bus_pkg;
  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_OWN  = 1'b1;
  function automatic int clog2w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/rr_priority_picker.sv
// rr_priority_picker: first requester found scanning upward from start_i with wrap
module rr_priority_picker import data_bus_pkg::*; #(
  parameter int NUM_SRC = 4,
  localparam int ID_W = clog2w(NUM_SRC)
) (
  input  logic [NUM_SRC-1:0] req_masked_i,
  input  logic [ID_W-1:0]    start_i,
  output logic [NUM_SRC-1:0] onehot_o,
  output logic [ID_W-1:0]    idx_o
);
  localparam logic [ID_W:0] NS = (ID_W+1)'(NUM_SRC);
  logic [ID_W:0] k;
  logic found;
  // Walk the sources from start_i, wrapping past the last one; the first hit wins
  always_comb begin
    onehot_o = '0;
    idx_o = '0;
    found = 1'b0;
    k = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      k = {1'b0, start_i} + (ID_W+1)'(i);
      if (k >= NS) k = k - NS;
      if (!found && req_masked_i[k[ID_W-1:0]]) begin
        found = 1'b1;
        onehot_o[k[ID_W-1:0]] = 1'b1;
        idx_o = k[ID_W-1:0];
      end
    end
  end
endmodule

// File: rtl/data_bus_arbiter_nto1.sv
// data_bus_arbiter_nto1: arbitrated N-to-1 data bus with registered grant and word
module data_bus_arbiter_nto1 import data_bus_pkg::*; #(
  parameter int NUM_SRC  = 4,
  parameter int DATA_W   = 8,
  parameter int RR_MODE  = 1,
  parameter int MAX_HOLD = 4,
  localparam int ID_W = clog2w(NUM_SRC)
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic [NUM_SRC-1:0]        req_i,
  input  logic [NUM_SRC*DATA_W-1:0] data_in_i,
  output logic [NUM_SRC-1:0]        grant_o,
  output logic [DATA_W-1:0]         data_out_o,
  output logic                      valid_o,
  output logic [ID_W-1:0]           owner_id_o
);
  localparam int HW = clog2w(MAX_HOLD + 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(MAX_HOLD);
  localparam logic [ID_W-1:0] LAST = ID_W'(NUM_SRC - 1);
  logic state_q, state_d;
  logic [NUM_SRC-1:0] grant_q, grant_d, win_oh;
  logic [ID_W-1:0] owner_q, owner_d, rr_q, rr_d, win_idx, start, sel;
  logic [HW-1:0] hold_q, hold_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic owner_req, others, keep, pick;
  assign owner_req = |(req_i & grant_q);
  assign others = |(req_i & ~grant_q);
  assign keep = (state_q == ST_OWN) && owner_req && (!others || hold_q < HOLD_MAX);
  assign pick = |req_i && !keep;
  assign start = (RR_MODE != 0) ? rr_q : '0;
  // The current owner is masked out, so a forced hand-over never re-picks it and a
  // dropped owner contributes nothing anyway.
  rr_priority_picker #(.NUM_SRC(NUM_SRC)) u_picker (
    .req_masked_i(req_i & ~grant_q),
    .start_i     (start),
    .onehot_o    (win_oh),
    .idx_o       (win_idx)
  );
  // State register
  always_ff @(posedge clk_i or posedge reset_i)
    if (reset_i) state_q <= ST_IDLE;
    else state_q <= state_d;
  // Any request means the bus has an owner after the edge; otherwise it goes idle
  always_comb state_d = |req_i ? ST_OWN : ST_IDLE;
  // Next register values: keep the owner, hand over to the winner, or clear to idle
  always_comb begin
    sel = keep ? owner_q : win_idx;
    grant_d = keep ? grant_q : (pick ? win_oh : '0);
    owner_d = (keep || pick) ? sel : '0;
    hold_d = keep ? ((hold_q < HOLD_MAX) ? hold_q + 1'b1 : hold_q) : (pick ? HW'(1) : '0);
    data_d = (keep || pick) ? data_in_i[sel*DATA_W +: DATA_W] : data_q;
    rr_d = (keep || pick) ? ((sel == LAST) ? '0 : sel + 1'b1) : rr_q;
  end
  // Output, hold-count and pointer registers; data_out keeps its last word when idle
  always_ff @(posedge clk_i or posedge reset_i)
    if (reset_i) begin
      grant_q <= '0;
      owner_q <= '0;
      hold_q <= '0;
      data_q <= '0;
      rr_q <= '0;
    end else begin
      grant_q <= grant_d;
      owner_q <= owner_d;
      hold_q <= hold_d;
      data_q <= data_d;
      rr_q <= rr_d;
    end
  assign grant_o = grant_q;
  assign data_out_o = data_q;
  assign valid_o = state_q;
  assign owner_id_o = owner_q;
endmodule

// File: tb/tb_data_bus_arbiter_nto1.sv
// tb_data_bus_arbiter_nto1: directed checks of round-robin and fixed-priority arbitration
module tb_data_bus_arbiter_nto1;
  logic clk = 1'b0;
  logic reset;
  logic [3:0] req, reqf, grant, grantf;
  logic [31:0] din;
  logic [7:0] dout, doutf;
  logic valid, validf;
  logic [1:0] oid, oidf;
  logic [7:0] src_b [4];
  int n_chk = 0;
  int n_fail = 0;
  always #5 clk = ~clk;
  data_bus_arbiter_nto1 #(.NUM_SRC(4), .DATA_W(8), .RR_MODE(1), .MAX_HOLD(4)) dut_rr (
    .clk_i(clk), .reset_i(reset), .req_i(req), .data_in_i(din),
    .grant_o(grant), .data_out_o(dout), .valid_o(valid), .owner_id_o(oid)
  );
  data_bus_arbiter_nto1 #(.NUM_SRC(4), .DATA_W(8), .RR_MODE(0), .MAX_HOLD(4)) dut_fp (
    .clk_i(clk), .reset_i(reset), .req_i(reqf), .data_in_i(din),
    .grant_o(grantf), .data_out_o(doutf), .valid_o(validf), .owner_id_o(oidf)
  );
  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk_rr(input string tag, input logic [3:0] g, input logic [1:0] id, input logic [7:0] d, input logic v);
    check({tag, ".grant"}, 32'(grant), 32'(g));
    check({tag, ".owner"}, 32'(oid), 32'(id));
    check({tag, ".data"}, 32'(dout), 32'(d));
    check({tag, ".valid"}, 32'(valid), 32'(v));
  endtask
  task automatic chk_fp(input string tag, input logic [3:0] g, input logic [1:0] id, input logic [7:0] d, input logic v);
    check({tag, ".grant"}, 32'(grantf), 32'(g));
    check({tag, ".owner"}, 32'(oidf), 32'(id));
    check({tag, ".data"}, 32'(doutf), 32'(d));
    check({tag, ".valid"}, 32'(validf), 32'(v));
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    src_b[0] = 8'h11;
    src_b[1] = 8'h22;
    src_b[2] = 8'hA5;
    src_b[3] = 8'h44;
    din = {src_b[3], src_b[2], src_b[1], src_b[0]};
    reset = 1'b1;
    req = 4'b1111;
    reqf = 4'b1111;
    #3;
    chk_rr("rst_rr", 4'b0000, 2'd0, 8'h00, 1'b0);
    chk_fp("rst_fp", 4'b0000, 2'd0, 8'h00, 1'b0);
    tick;
    chk_rr("rst_edge", 4'b0000, 2'd0, 8'h00, 1'b0);
    req = 4'b0000;
    reqf = 4'b0000;
    reset = 1'b0;
    req = 4'b0100;
    tick;
    chk_rr("single", 4'b0100, 2'd2, 8'hA5, 1'b1);
    req = 4'b0000;
    tick;
    chk_rr("single_drop", 4'b0000, 2'd0, 8'hA5, 1'b0);
    #2 reset = 1'b1;
    #2 reset = 1'b0;
    req = 4'b1111;
    for (int t = 0; t < 17; t++) begin
      tick;
      chk_rr($sformatf("rr_t%0d", t), 4'(1 << ((t / 4) % 4)), 2'((t / 4) % 4), src_b[(t / 4) % 4], 1'b1);
    end
    req = 4'b0010;
    tick;
    chk_rr("zb_own1", 4'b0010, 2'd1, 8'h22, 1'b1);
    req = 4'b1010;
    tick;
    chk_rr("zb_keep1", 4'b0010, 2'd1, 8'h22, 1'b1);
    req = 4'b1000;
    tick;
    chk_rr("zb_hand", 4'b1000, 2'd3, 8'h44, 1'b1);
    req = 4'b0000;
    tick;
    chk_rr("zb_idle", 4'b0000, 2'd0, 8'h44, 1'b0);
    req = 4'b0010;
    tick;
    chk_rr("ar_own", 4'b0010, 2'd1, 8'h22, 1'b1);
    #2 reset = 1'b1;
    #1;
    chk_rr("ar_clear", 4'b0000, 2'd0, 8'h00, 1'b0);
    reset = 1'b0;
    tick;
    chk_rr("ar_regrant", 4'b0010, 2'd1, 8'h22, 1'b1);
    req = 4'b0000;
    reqf = 4'b0110;
    for (int t = 0; t < 9; t++) begin
      tick;
      if (t >= 4 && t < 8) chk_fp($sformatf("fp_t%0d", t), 4'b0100, 2'd2, 8'hA5, 1'b1);
      else chk_fp($sformatf("fp_t%0d", t), 4'b0010, 2'd1, 8'h22, 1'b1);
    end
    reqf = 4'b1001;
    tick;
    chk_fp("fp_lowest", 4'b0001, 2'd0, 8'h11, 1'b1);
    reqf = 4'b0000;
    tick;
    chk_fp("fp_idle", 4'b0000, 2'd0, 8'h11, 1'b0);
    chk_rr("rr_idle_end", 4'b0000, 2'd0, 8'h22, 1'b0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
